// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared encodings, tx state enumeration and frame-length helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles a complete frame occupies the line (start + data + parity + stop).
  function automatic int frame_len(input int cpb, input int db, input int par, input int sb);
    return cpb * (1 + db + ((par != PARITY_NONE) ? 1 : 0) + sb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg_if
// Brief    : Valid/ready word handshake between a producer and the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Bit-period counter; pulses bit_end on the last cycle of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en,
  output logic      bit_end
);
  localparam int                c_cw   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0]   c_last = c_cw'(CLKS_PER_BIT - 1);

  logic [c_cw-1:0] r_cnt;

  // Held at zero while disabled so every frame starts on a full bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  assign bit_end = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Brief    : Parametrised UART transmitter (5..9 data bits, none/odd/even
//            parity, 1 or 2 stop bits) with a valid/ready word input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  uart_tx_cfg_if.slave s_if,
  output logic         tx,
  output logic         busy,
  output logic         done
);
  localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (CLKS_PER_BIT < 2) ||
      (PARITY < PARITY_NONE) || (PARITY > PARITY_EVEN) ||
      ((STOP_BITS != 1) && (STOP_BITS != 2))) begin : g_bad_params
    $error("uart_tx_cfg: unsupported parameter combination");
  end

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [3:0]           r_bit_cnt;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_tx_next;
  logic                 w_ready_next;
  logic                 w_busy_next;
  logic                 w_done_next;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_baud_en;

  assign w_accept  = s_if.s_valid && r_ready;
  assign w_baud_en = (r_state != ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (w_baud_en),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_state_next = ST_START;
      ST_START:  if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA:   if (w_bit_end && (r_bit_cnt == c_last_data))
                   w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
      ST_STOP:   if (w_bit_end && (r_bit_cnt == c_last_stop)) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Line level is decided from the state being entered so tx lands on the bit boundary.
  always_comb begin
    w_shift_next = r_shift;
    if ((r_state == ST_IDLE) && w_accept) begin
      w_shift_next = s_if.s_data;
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      w_shift_next = r_shift >> 1;
    end

    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = r_par;
      default:   w_tx_next = 1'b1;
    endcase

    w_ready_next = (w_state_next == ST_IDLE);
    w_busy_next  = (w_state_next != ST_IDLE);
    w_done_next  = (r_state == ST_STOP) && (w_state_next == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      if (w_accept) begin
        r_par <= (^s_if.s_data) ^ (PARITY == PARITY_ODD);
      end
      // One counter serves both data bits and stop bits; it restarts on every state change.
      if (w_bit_end) begin
        r_bit_cnt <= (w_state_next != r_state) ? 4'd0 : (r_bit_cnt + 4'd1);
      end
    end
  end

  assign s_if.s_ready = r_ready;
  assign tx           = r_tx;
  assign busy         = r_busy;
  assign done         = r_done;

`ifndef SYNTHESIS
  int r_frame_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cycles <= 0;
    end else if (r_busy) begin
      r_frame_cycles <= r_frame_cycles + 1;
    end else begin
      r_frame_cycles <= 0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_done) begin
      assert (r_frame_cycles == frame_len(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Brief    : Four transmitter configurations checked cycle by cycle against a
//            frame-level model, plus hand-computed line checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int NCFG = 4;
  localparam int CPB  = 4;
  localparam int CFG_DB  [NCFG] = '{8, 8, 8, 7};
  localparam int CFG_PAR [NCFG] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
  localparam int CFG_SB  [NCFG] = '{1, 1, 1, 2};

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [8:0]      s_data [NCFG];
  logic [NCFG-1:0] s_valid;
  logic [NCFG-1:0] ready;
  logic [NCFG-1:0] tx;
  logic [NCFG-1:0] busy;
  logic [NCFG-1:0] done;

  int n_checks = 0;
  int n_errors = 0;

  logic rec_tx    [0:63];
  logic rec_busy  [0:63];
  logic rec_ready [0:63];
  logic rec_done  [0:63];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int limit);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no response within %0d cycles", name, limit);
  endtask

  // Line level of bit b of a frame carrying d, derived from the framing rules.
  function automatic logic frame_bit(input logic [8:0] d, input int b, input int db, input int par);
    logic p;
    p = 1'b0;
    if (b == 0) return 1'b0;
    if (b <= db) return d[b-1];
    if ((par != PARITY_NONE) && (b == db + 1)) begin
      for (int k = 0; k < db; k++) p ^= d[k];
      return (par == PARITY_EVEN) ? p : ~p;
    end
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int DB  = CFG_DB[gi];
    localparam int PAR = CFG_PAR[gi];
    localparam int SB  = CFG_SB[gi];

    uart_tx_cfg_if #(.DATA_BITS(DB)) u_if ();
    assign u_if.s_data  = s_data[gi][DB-1:0];
    assign u_if.s_valid = s_valid[gi];
    assign ready[gi]    = u_if.s_ready;

    uart_tx_cfg #(
      .DATA_BITS    (DB),
      .CLKS_PER_BIT (CPB),
      .PARITY       (PAR),
      .STOP_BITS    (SB)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_if  (u_if),
      .tx    (tx[gi]),
      .busy  (busy[gi]),
      .done  (done[gi])
    );

    // Expected {tx, busy, ready, done} for the current cycle; idle is 4'b1010.
    logic [3:0] exp_now = 4'b1010;
    logic [3:0] exp_q [$];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_now <= 4'b1010;
      end else begin
        if (s_valid[gi] && exp_now[1]) begin
          for (int b = 0; b < frame_len(1, DB, PAR, SB); b++)
            repeat (CPB) exp_q.push_back({frame_bit(s_data[gi], b, DB, PAR), 3'b100});
          exp_q.push_back(4'b1011);
        end
        if (exp_q.size() > 0) begin
          exp_now <= exp_q[0];
          exp_q.delete(0);
        end else begin
          exp_now <= 4'b1010;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("cfg%0d tx/busy/ready/done", gi),
            32'({tx[gi], busy[gi], ready[gi], done[gi]}), 32'(exp_now));
    end
  end

  task automatic send(input int i, input logic [8:0] d);
    int n;
    n = 0;
    @(negedge clk);
    s_data[i]  = d;
    s_valid[i] = 1'b1;
    while (!ready[i] && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now($sformatf("cfg%0d handshake", i), 200);
    @(posedge clk);
    #1;
    s_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ready[i] && !busy[i]) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now($sformatf("cfg%0d return to idle", i), 200);
  endtask

  // Cycle j (1-based) is the j-th cycle after the accept edge.
  task automatic record(input int i, input int n);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      rec_tx[j]    = tx[i];
      rec_busy[j]  = busy[i];
      rec_ready[j] = ready[i];
      rec_done[j]  = done[i];
    end
  endtask

  // Mid-bit samples of bits first..first+n-1, first transmitted bit in the MSB.
  function automatic logic [15:0] sample_bits(input int first, input int n);
    logic [15:0] v;
    v = '0;
    for (int k = first; k < first + n; k++) v = {v[14:0], rec_tx[CPB*k+2]};
    return v;
  endfunction

  function automatic int count_ones(input int which, input int lo, input int hi);
    int c;
    c = 0;
    for (int j = lo; j <= hi; j++) begin
      case (which)
        0:       c += int'(rec_tx[j]);
        1:       c += int'(rec_busy[j]);
        2:       c += int'(rec_ready[j]);
        default: c += int'(rec_done[j]);
      endcase
    end
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NCFG; i++) s_data[i] = '0;
    s_valid = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCFG; i++)
      check($sformatf("cfg%0d reset outputs", i),
            32'({tx[i], busy[i], ready[i], done[i]}), 32'h0000000a);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, 0xA5
    send(0, 9'h0A5);
    record(0, 48);
    check("8N1 A5 line pattern", 32'(sample_bits(0, 10)), 32'b0101001011);
    check("8N1 busy cycles", count_ones(1, 1, 48), 40);
    check("8N1 done pulse count", count_ones(3, 1, 48), 1);
    check("8N1 done on cycle 41", 32'(rec_done[41]), 32'd1);
    wait_idle(0);

    // Even and odd parity, 0x07
    send(1, 9'h007);
    record(1, 48);
    check("8E1 parity bit", 32'(rec_tx[38]), 32'd1);
    check("8E1 busy cycles", count_ones(1, 1, 48), 44);
    wait_idle(1);
    send(2, 9'h007);
    record(2, 48);
    check("8O1 parity bit", 32'(rec_tx[38]), 32'd0);
    check("8O1 busy cycles", count_ones(1, 1, 48), 44);
    wait_idle(2);

    // 7N2, 0x41, second word waiting from the first busy cycle
    send(3, 9'h041);
    s_data[3]  = 9'h02A;
    s_valid[3] = 1'b1;
    record(3, 45);
    s_valid[3] = 1'b0;
    check("7N2 stop level cycles", count_ones(0, 33, 40), 8);
    check("7N2 ready while busy", count_ones(2, 1, 40), 0);
    check("7N2 done on cycle 41", 32'(rec_done[41]), 32'd1);
    check("7N2 second start bit", 32'(rec_tx[42]), 32'd0);
    check("7N2 second frame busy", 32'(rec_busy[42]), 32'd1);
    wait_idle(3);

    // Back-to-back 0x55 then 0xAA with valid held
    @(negedge clk);
    s_data[0]  = 9'h055;
    s_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    s_data[0] = 9'h0AA;
    record(0, 45);
    s_valid[0] = 1'b0;
    check("b2b gap tx", 32'(rec_tx[41]), 32'd1);
    check("b2b gap ready", 32'(rec_ready[41]), 32'd1);
    check("b2b ready cycles", count_ones(2, 1, 45), 1);
    check("b2b second start bit", 32'(rec_tx[42]), 32'd0);
    wait_idle(0);

    // 0x3C in flight while 0xFF is offered
    send(0, 9'h03C);
    fork
      record(0, 50);
      begin
        repeat (8) @(negedge clk);
        send(0, 9'h0FF);
      end
    join
    check("midframe data bits", 32'(sample_bits(1, 8)), 32'b00111100);
    check("midframe pending start", 32'(rec_tx[42]), 32'd0);
    wait_idle(0);

    // Reset during data bit 3 of 0xF0
    send(0, 9'h0F0);
    repeat (18) @(negedge clk);
    check("pre-reset data bit 3", 32'(tx[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset tx", 32'(tx[0]), 32'd1);
    check("async reset busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    record(0, 50);
    check("post-reset idle tx", count_ones(0, 1, 50), 50);
    check("post-reset busy", count_ones(1, 1, 50), 0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
